// File: rtl/hit_or_tdc_tagger.sv
// Purpose : timestamps and measures HIT_OR pulses, packing each one into a 32-bit word held in a show-ahead FIFO.
// Latency : a HIT_IN edge reaches hit_s after 3 cycles; the word is on FIFO_DATA 2 cycles after fall is detected.
// Backpr. : if the FIFO is full with no pop in the PUSH cycle, the word is dropped and LOST_CNT counts it (saturating).
//
// Ports:
//   BUS_CLK     single clock for all logic
//   BUS_RST_N   asynchronous active-low reset
//   EN          capture enable; dropping it mid-pulse aborts that pulse silently
//   HIT_IN      asynchronous HIT_OR from the DUT
//   FIFO_READ   pop strobe; ignored while FIFO_EMPTY=1
//   FIFO_EMPTY  no word available
//   FIFO_DATA   head word {DATA_IDENTIFIER, ts[15:0], tot[11:0]}; zero while empty
//   LOST_CNT    dropped-pulse count, saturates at 8'hFF
//   BUSY        high while a pulse is measured or being pushed
module hit_or_tdc_tagger #(
  parameter logic [3:0]  DATA_IDENTIFIER = 4'b0101,
  parameter int          FIFO_DEPTH      = 16,
  parameter logic [11:0] TOT_MAX         = 12'hFFF
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  input  logic        EN,
  input  logic        HIT_IN,
  input  logic        FIFO_READ,
  output logic        FIFO_EMPTY,
  output logic [31:0] FIFO_DATA,
  output logic [7:0]  LOST_CNT,
  output logic        BUSY
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    PUSH = 2'd2
  } state_t;

  // ---------------------------------------------------------------
  // Input synchroniser and edge detection
  // ---------------------------------------------------------------
  logic [2:0] sync_ff;
  logic       hit_s;
  logic       hit_q;
  logic       rise;
  logic       fall;

  assign hit_s = sync_ff[2];
  assign rise  = hit_s & ~hit_q;
  assign fall  = ~hit_s & hit_q;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      sync_ff <= 3'b000;
      hit_q   <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[1:0], HIT_IN};
      hit_q   <= hit_s;
    end
  end

  // ---------------------------------------------------------------
  // Free-running timestamp, independent of EN
  // ---------------------------------------------------------------
  logic [15:0] ts_cnt;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      ts_cnt <= 16'h0000;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------
  // Pulse measurement FSM
  // ---------------------------------------------------------------
  state_t      state;
  state_t      state_nxt;
  logic [15:0] ts_q;
  logic [15:0] ts_nxt;
  logic [11:0] tot_q;
  logic [11:0] tot_nxt;
  logic        push;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state <= IDLE;
      ts_q  <= 16'h0000;
      tot_q <= 12'h000;
    end else begin
      state <= state_nxt;
      ts_q  <= ts_nxt;
      tot_q <= tot_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ts_nxt    = ts_q;
    tot_nxt   = tot_q;
    push      = 1'b0;
    case (state)
      IDLE: begin
        // The rise cycle itself is the first high cycle, hence tot starts at 1.
        if (rise && EN) begin
          ts_nxt    = ts_cnt;
          tot_nxt   = 12'd1;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (!EN) begin
          state_nxt = IDLE;
        end else if (fall) begin
          state_nxt = PUSH;
        end else if (hit_s && (tot_q != TOT_MAX)) begin
          tot_nxt = tot_q + 12'd1;
        end
      end
      PUSH: begin
        // Any rise arriving here is not sampled by IDLE, so it is ignored.
        push      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign BUSY = (state != IDLE);

  // ---------------------------------------------------------------
  // Show-ahead output FIFO
  // ---------------------------------------------------------------
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic        full;
  logic        rd_ok;
  logic        wr_ok;
  logic        drop;
  logic [31:0] word;

  assign word       = {DATA_IDENTIFIER, ts_q, tot_q};
  assign count      = wr_ptr - rd_ptr;
  assign FIFO_EMPTY = (count == '0);
  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign rd_ok      = FIFO_READ & ~FIFO_EMPTY;
  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign wr_ok      = push & (~full | rd_ok);
  assign drop       = push & full & ~rd_ok;
  // Gated so that unwritten memory never shows on the bus while empty.
  assign FIFO_DATA  = FIFO_EMPTY ? 32'h0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge BUS_CLK) begin
    if (wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= word;
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      LOST_CNT <= 8'h00;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (drop && (LOST_CNT != 8'hFF)) begin
        LOST_CNT <= LOST_CNT + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hit_or_tdc_tagger.sv
// Testbench for hit_or_tdc_tagger: directed pulses with table-driven single-word checks
// and hand-written sequences for saturation, FIFO full/empty corners, EN abort, reset and ts wrap.
module tb_hit_or_tdc_tagger;

  logic        BUS_CLK;
  logic        BUS_RST_N;
  logic        EN;
  logic        HIT_IN;
  logic        FIFO_READ;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  logic [7:0]  LOST_CNT;
  logic        BUSY;

  hit_or_tdc_tagger dut (
    .BUS_CLK   (BUS_CLK),
    .BUS_RST_N (BUS_RST_N),
    .EN        (EN),
    .HIT_IN    (HIT_IN),
    .FIFO_READ (FIFO_READ),
    .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_DATA (FIFO_DATA),
    .LOST_CNT  (LOST_CNT),
    .BUSY      (BUSY)
  );

  initial BUS_CLK = 1'b0;
  always #5 BUS_CLK = ~BUS_CLK;

  // Reference cycle counter: the value ts_cnt should hold after each edge.
  logic [15:0] cyc;
  always @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) cyc <= 16'h0000;
    else            cyc <= cyc + 16'd1;
  end

  // Head-word stability watcher.
  logic        watch;
  logic [31:0] watch_word;
  int          glitches;
  initial glitches = 0;
  always @(negedge BUS_CLK) begin
    if (watch && (FIFO_DATA !== watch_word)) glitches++;
  end

  int passed;
  int total;
  logic [31:0] exp_q[$];

  typedef struct {
    int          width;
    logic [11:0] tot;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic logic [11:0] tot_of(input int width);
    if (width >= 4095) return 12'hFFF;
    return width[11:0];
  endfunction

  // Called at #1 after an edge; returns at #1 after an edge, word already visible.
  task automatic pulse(input int width, input int gap, output logic [31:0] w);
    logic [15:0] t;
    t = cyc + 16'd3;
    HIT_IN = 1'b1;
    repeat (width) @(posedge BUS_CLK);
    #1 HIT_IN = 1'b0;
    repeat (gap) @(posedge BUS_CLK);
    #1;
    w = {4'h5, t, tot_of(width)};
  endtask

  // Pulse with FIFO_READ held high exactly during the PUSH cycle.
  task automatic pulse_rd(input int width, output logic [31:0] w,
                          output logic [31:0] head, output logic emp);
    logic [15:0] t;
    t = cyc + 16'd3;
    HIT_IN = 1'b1;
    repeat (width) @(posedge BUS_CLK);
    #1 HIT_IN = 1'b0;
    repeat (4) @(posedge BUS_CLK);
    #1;
    head = FIFO_DATA;
    emp  = FIFO_EMPTY;
    FIFO_READ = 1'b1;
    @(posedge BUS_CLK);
    #1 FIFO_READ = 1'b0;
    repeat (3) @(posedge BUS_CLK);
    #1;
    w = {4'h5, t, tot_of(width)};
  endtask

  task automatic pop_chk(input string name);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
    chk({name, " nonempty"}, 32'(FIFO_EMPTY), 32'd0);
    chk(name, FIFO_DATA, e);
    FIFO_READ = 1'b1;
    @(posedge BUS_CLK);
    #1 FIFO_READ = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] head;
    logic        emp;
    logic [15:0] t;
    int          bad;

    passed = 0;
    total  = 0;
    watch  = 1'b0;
    watch_word = 32'h0;
    BUS_RST_N = 1'b0;
    EN        = 1'b1;
    HIT_IN    = 1'b0;
    FIFO_READ = 1'b0;
    vecs[0] = '{5,   12'd5};
    vecs[1] = '{1,   12'd1};
    vecs[2] = '{2,   12'd2};
    vecs[3] = '{7,   12'd7};
    vecs[4] = '{100, 12'h064};
    vecs[5] = '{300, 12'h12C};

    repeat (2) @(posedge BUS_CLK);
    #1 BUS_RST_N = 1'b1;

    // Reset state
    chk("rst empty", 32'(FIFO_EMPTY), 32'd1);
    chk("rst data",  FIFO_DATA, 32'h0);
    chk("rst lost",  32'(LOST_CNT), 32'd0);
    chk("rst busy",  32'(BUSY), 32'd0);

    // Pop on empty is ignored
    FIFO_READ = 1'b1;
    repeat (2) @(posedge BUS_CLK);
    #1 FIFO_READ = 1'b0;
    chk("rd empty ignored", 32'(FIFO_EMPTY), 32'd1);

    // Table-driven single pulses
    foreach (vecs[i]) begin
      pulse(vecs[i].width, 6, w);
      exp_q.push_back(w);
      chk($sformatf("vec%0d id", i),  32'(FIFO_DATA[31:28]), 32'h5);
      chk($sformatf("vec%0d tot", i), 32'(FIFO_DATA[11:0]), 32'(vecs[i].tot));
      chk($sformatf("vec%0d ts", i),  32'(FIFO_DATA[27:12]), 32'(w[27:12]));
      pop_chk($sformatf("vec%0d word", i));
      chk($sformatf("vec%0d empty after pop", i), 32'(FIFO_EMPTY), 32'd1);
    end

    // Long pulse: tot saturates, BUSY held throughout
    t = cyc + 16'd3;
    bad = 0;
    HIT_IN = 1'b1;
    repeat (4) @(posedge BUS_CLK);
    #1;
    for (int i = 0; i < 4996; i++) begin
      if (BUSY !== 1'b1) bad++;
      @(posedge BUS_CLK);
      #1;
    end
    HIT_IN = 1'b0;
    chk("long busy cycles low", 32'(bad), 32'd0);
    repeat (4) @(posedge BUS_CLK);
    #1 chk("long busy in push", 32'(BUSY), 32'd1);
    @(posedge BUS_CLK);
    #1;
    chk("long busy after push", 32'(BUSY), 32'd0);
    exp_q.push_back({4'h5, t, 12'hFFF});
    chk("long tot sat", 32'(FIFO_DATA[11:0]), 32'hFFF);
    pop_chk("long word");

    // 18 pulses into a 16-deep FIFO with no reads
    for (int i = 0; i < 18; i++) begin
      pulse(i + 1, 6, w);
      if (i < 16) exp_q.push_back(w);
    end
    chk("overflow lost", 32'(LOST_CNT), 32'd2);
    for (int i = 0; i < 16; i++) pop_chk($sformatf("ovf word%0d", i));
    chk("ovf drained", 32'(FIFO_EMPTY), 32'd1);

    // Full FIFO, pop in the PUSH cycle: write must land
    for (int i = 0; i < 16; i++) begin
      pulse(3, 6, w);
      exp_q.push_back(w);
    end
    pulse_rd(4, w, head, emp);
    chk("full rw head", head, exp_q[0]);
    chk("full rw nonempty", 32'(emp), 32'd0);
    void'(exp_q.pop_front());
    exp_q.push_back(w);
    chk("full rw lost", 32'(LOST_CNT), 32'd2);
    for (int i = 0; i < 16; i++) pop_chk($sformatf("full rw word%0d", i));
    chk("full rw drained", 32'(FIFO_EMPTY), 32'd1);

    // Empty FIFO, pop in the PUSH cycle: write stored, pop ignored
    pulse_rd(6, w, head, emp);
    chk("empty rw emp", 32'(emp), 32'd1);
    exp_q.push_back(w);
    pop_chk("empty rw word");
    chk("empty rw drained", 32'(FIFO_EMPTY), 32'd1);

    // Timestamp wrap
    for (int i = 0; i < 70000; i++) begin
      if (cyc == 16'hFFFB) break;
      @(posedge BUS_CLK);
      #1;
    end
    chk("wrap align", 32'(cyc), 32'h0000FFFB);
    pulse(3, 6, w);
    exp_q.push_back(w);
    chk("wrap ts FFFE", 32'(FIFO_DATA[27:12]), 32'h0000FFFE);
    watch_word = FIFO_DATA;
    watch = 1'b1;
    pulse(2, 6, w);
    exp_q.push_back(w);
    watch = 1'b0;
    chk("wrap head stable", 32'(glitches), 32'd0);
    pop_chk("wrap word0");
    chk("wrap ts small", 32'(FIFO_DATA[27:12] < 16'h0010), 32'd1);
    pop_chk("wrap word1");

    // EN dropped mid-pulse: no word, LOST_CNT unchanged
    HIT_IN = 1'b1;
    repeat (10) @(posedge BUS_CLK);
    #1 EN = 1'b0;
    @(posedge BUS_CLK);
    #1 EN = 1'b1;
    repeat (10) @(posedge BUS_CLK);
    #1 HIT_IN = 1'b0;
    repeat (8) @(posedge BUS_CLK);
    #1;
    chk("abort no word", 32'(FIFO_EMPTY), 32'd1);
    chk("abort lost", 32'(LOST_CNT), 32'd2);
    chk("abort idle", 32'(BUSY), 32'd0);

    // LOST_CNT saturation
    for (int i = 0; i < 16; i++) begin
      pulse(2, 6, w);
      exp_q.push_back(w);
    end
    for (int i = 0; i < 260; i++) pulse(1, 5, w);
    chk("lost saturate", 32'(LOST_CNT), 32'd255);
    for (int i = 0; i < 13; i++) pop_chk($sformatf("sat word%0d", i));

    // Reset mid-pulse with 3 words queued
    HIT_IN = 1'b1;
    repeat (8) @(posedge BUS_CLK);
    #1 chk("pre-rst busy", 32'(BUSY), 32'd1);
    BUS_RST_N = 1'b0;
    #1;
    chk("mid rst empty", 32'(FIFO_EMPTY), 32'd1);
    chk("mid rst lost",  32'(LOST_CNT), 32'd0);
    chk("mid rst busy",  32'(BUSY), 32'd0);
    chk("mid rst data",  FIFO_DATA, 32'h0);
    HIT_IN = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge BUS_CLK);
    #1 BUS_RST_N = 1'b1;
    repeat (10) @(posedge BUS_CLK);
    #1;
    chk("post rst empty", 32'(FIFO_EMPTY), 32'd1);
    pulse(4, 6, w);
    exp_q.push_back(w);
    chk("post rst tot", 32'(FIFO_DATA[11:0]), 32'd4);
    pop_chk("post rst word");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
